inst_mem_loader: RTL
====================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, instruction memory address width; DEPTH = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, instruction word width.
REQ-003 Port: clk  input  1  single clock for all logic.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: s_axis_TDATA  input  DATA_WIDTH  program word stream.
REQ-006 Port: s_axis_TVALID  input  1  stream beat valid.
REQ-007 Port: s_axis_TREADY  output  1  stream beat accepted when TVALID & TREADY.
REQ-008 Port: s_axis_TLAST  input  1  marks final program word.
REQ-009 Port: load_req  input  1  level request to load a new program.
REQ-010 Port: cpu_idle  input  1  CPU reports it is not fetching.
REQ-011 Port: cpu_halt  output  1  holds CPU fetch stopped.
REQ-012 Port: cpu_start  output  1  one-cycle pulse: program loaded; CPU restarts at address 0.
REQ-013 Port: wr_addr  output  ADDR_WIDTH  instruction memory write address.
REQ-014 Port: wr_data  output  DATA_WIDTH  instruction memory write data.
REQ-015 Port: wr_en  output  1  instruction memory write strobe.
REQ-016 Port: prog_len  output  ADDR_WIDTH+1  word count of last successful load.
REQ-017 Port: load_err  output  1  sticky overflow flag.

Function
REQ-018 SHALL implement states HALT, RUN, DRAIN, LOAD, FINISH, DISCARD.
REQ-019 HALT: load_req=1 -> LOAD next cycle.
REQ-020 RUN: load_req=1 -> DRAIN next cycle.
REQ-021 DRAIN: cpu_idle=1 -> LOAD next cycle; otherwise remain.
REQ-022 On entry to LOAD, word counter SHALL be 0 and load_err SHALL clear.
REQ-023 s_axis_TREADY SHALL be 1 exactly in LOAD and DISCARD, 0 otherwise.
REQ-024 Beat accepted in LOAD with counter < DEPTH: next cycle wr_en=1, wr_addr=counter[ADDR_WIDTH-1:0], wr_data=beat TDATA; counter increments by 1.
REQ-025 wr_en, wr_addr, wr_data SHALL be registered; wr_en=0 in all cycles without an accepted in-range beat the cycle before.
REQ-026 Accepted in-range beat with TLAST=1: LOAD -> FINISH; prog_len takes the incremented counter value.
REQ-027 FINISH lasts one cycle (the final wr_en cycle), then RUN; cpu_start=1 in the first RUN cycle only.
REQ-028 Beat accepted in LOAD with counter == DEPTH SHALL NOT be written; load_err set to 1; TLAST=1 -> HALT, else -> DISCARD.
REQ-029 DISCARD: beats accepted and dropped, no writes; accepted beat with TLAST=1 -> HALT.
REQ-030 cpu_halt SHALL be 1 in HALT, DRAIN, LOAD, FINISH, DISCARD; 0 in RUN only.
REQ-031 load_req SHALL be ignored in DRAIN, LOAD, FINISH, DISCARD.
REQ-032 Cycles with TVALID=0 in LOAD SHALL not advance counter or state.
REQ-033 prog_len SHALL be unchanged on overflowed loads.

Reset
REQ-034 rst=1 SHALL force next state HALT, counter 0, cpu_halt=1, cpu_start=0, wr_en=0, s_axis_TREADY=0, prog_len=0, load_err=0, wr_addr=0, wr_data=0.
REQ-035 rst mid-LOAD SHALL abandon the load; memory holds partial contents; CPU stays halted until next load completes.

Verification
REQ-036 From reset, load_req=1, 3 beats 0xA,0xB,0xC (TLAST on 0xC), TVALID constant -> wr_en at addresses 0,1,2 on consecutive cycles, FINISH, cpu_start pulse 1 cycle after last wr_en, cpu_halt=0, prog_len=3.
REQ-037 RUN, load_req=1, cpu_idle=0 for 5 cycles then 1 -> cpu_halt=1 from DRAIN entry, TREADY stays 0 until cycle after cpu_idle=1.
REQ-038 ADDR_WIDTH=2, 5 beats TLAST on beat 5 -> writes addr 0..3 only, load_err=1, state HALT, no cpu_start, prog_len unchanged.
REQ-039 ADDR_WIDTH=2, 7 beats TLAST on beat 7 -> beats 5-7 dropped in DISCARD, HALT after beat 7, load_err=1; new load_req clears load_err.
REQ-040 ADDR_WIDTH=2, exactly 4 beats TLAST on beat 4 -> no error, prog_len=4, cpu_start pulses.
REQ-041 rst asserted after 2 of 4 beats, TVALID gaps inserted -> all outputs at reset values next cycle, cpu_halt=1, no further wr_en.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Streams a program into instruction memory while holding the CPU stopped. The CPU is
// restarted at address 0 once a load fits in memory; an overflowing load is dropped.
module inst_mem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_TDATA,
  input  logic                  s_axis_TVALID,
  output logic                  s_axis_TREADY,
  input  logic                  s_axis_TLAST,
  input  logic                  load_req,
  input  logic                  cpu_idle,
  output logic                  cpu_halt,
  output logic                  cpu_start,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH:0]   prog_len,
  output logic                  load_err
);

  typedef enum logic [2:0] {HALT, RUN, DRAIN, LOAD, FINISH, DISCARD} state_t;

  // Counter value meaning "memory full": one past the last address.
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH:0]     cnt_reg;
  logic [ADDR_WIDTH:0]     prog_len_reg;
  logic                    load_err_reg;
  logic                    start_reg;
  logic                    wr_en_reg;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg;
  logic [DATA_WIDTH-1:0]   wr_data_reg;
  logic                    accept;
  logic                    in_range;

  assign s_axis_TREADY = ~rst & ((state_reg == LOAD) | (state_reg == DISCARD));
  assign accept        = s_axis_TVALID & s_axis_TREADY;
  assign in_range      = (cnt_reg != DEPTH_CNT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HALT:    if (load_req) state_next = LOAD;
      RUN:     if (load_req) state_next = DRAIN;
      DRAIN:   if (cpu_idle) state_next = LOAD;
      LOAD: begin
        if (accept) begin
          if (in_range) begin
            if (s_axis_TLAST) state_next = FINISH;
          end else begin
            state_next = s_axis_TLAST ? HALT : DISCARD;
          end
        end
      end
      FINISH:  state_next = RUN;
      DISCARD: if (accept && s_axis_TLAST) state_next = HALT;
      default: state_next = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= HALT;
      cnt_reg      <= '0;
      prog_len_reg <= '0;
      load_err_reg <= 1'b0;
      start_reg    <= 1'b0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      start_reg <= (state_reg == FINISH);
      wr_en_reg <= 1'b0;
      if (state_reg != LOAD && state_next == LOAD) begin
        cnt_reg      <= '0;
        load_err_reg <= 1'b0;
      end
      if (state_reg == LOAD && accept) begin
        if (in_range) begin
          wr_en_reg   <= 1'b1;
          wr_addr_reg <= cnt_reg[ADDR_WIDTH-1:0];
          wr_data_reg <= s_axis_TDATA;
          cnt_reg     <= cnt_reg + 1'b1;
          if (s_axis_TLAST) prog_len_reg <= cnt_reg + 1'b1;
        end else begin
          // Overflow: the already-written words stay, but the CPU is not restarted.
          load_err_reg <= 1'b1;
        end
      end
    end
  end

  assign cpu_halt  = rst | (state_reg != RUN);
  assign cpu_start = start_reg;
  assign wr_en     = wr_en_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign prog_len  = prog_len_reg;
  assign load_err  = load_err_reg;

endmodule
